// File: rtl/proc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proc_pkg : instruction and fetch-group widths shared by fetch and issue
// Rev 1.0
// ----------------------------------------------------------------------------
package proc_pkg;
  localparam int INSTR_W = 16;
  localparam int FETCH_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [FETCH_W-1:0] fetch_grp_t;
endpackage
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_queue : circular 16-bit instruction queue, 2 write / 2 read ports
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_queue
  import proc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [FETCH_W-1:0]     wr_grp_i,
  input  logic [1:0]             consume_i,
  output logic [INSTR_W-1:0]     rd0_o,
  output logic [INSTR_W-1:0]     rd1_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]   w_head1, w_tail1;
  logic [CNT_W-1:0]   count_q, count_d;

  assign w_head1 = head_q + PTR_W'(1);
  assign w_tail1 = tail_q + PTR_W'(1);

  // Consume and refill may land on the same edge; the caller guarantees room.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(consume_i);
      count_d = count_q - CNT_W'(consume_i);
      if (wr_en_i) begin
        tail_d  = tail_q + PTR_W'(2);
        count_d = count_d + CNT_W'(2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      mem_q[tail_q]  <= wr_grp_i[INSTR_W-1:0];
      mem_q[w_tail1] <= wr_grp_i[FETCH_W-1:INSTR_W];
    end
  end

  assign rd0_o   = mem_q[head_q];
  assign rd1_o   = mem_q[w_head1];
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/fetch_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_feeder : fetch PC / single-outstanding fetch control feeding issue
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_feeder
  import proc_pkg::*;
#(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [FETCH_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  input  logic               isstall,
  input  logic               issingleinstr,
  output logic [INSTR_W-1:0] instr1_o,
  output logic [INSTR_W-1:0] instr2_o
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic [15:0]        pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic               hold_q, hold_d;
  logic               epoch_q, epoch_d;
  logic               req_epoch_q, req_epoch_d;

  logic [CNT_W-1:0]   w_count;
  logic [INSTR_W-1:0] w_rd0, w_rd1;
  logic [1:0]         w_lim, w_consume;
  logic               w_room, w_accept;

  always_comb begin
    w_lim = hold_q ? 2'd1 : 2'd2;
    if (isstall)
      w_consume = 2'd0;
    else if (w_count < CNT_W'(w_lim))
      w_consume = w_count[1:0];
    else
      w_consume = w_lim;
  end

  assign w_room   = ({1'b0, w_count} - (CNT_W+1)'(w_consume) + (CNT_W+1)'(2))
                    <= (CNT_W+1)'(QDEPTH);
  assign imem_req  = !rst && !inflight_q && !redirect_valid && w_room;
  assign imem_addr = pc_q;

  // Returned data is kept only for a live request issued in the current epoch.
  assign w_accept = imem_rvalid && !redirect_valid && inflight_q && (req_epoch_q == epoch_q);

  always_comb begin
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    hold_d      = issingleinstr && !isstall;
    if (redirect_valid) begin
      pc_d       = redirect_pc & 16'hFFFE;
      inflight_d = 1'b0;
      epoch_d    = !epoch_q;
      hold_d     = 1'b0;
    end else if (imem_req) begin
      pc_d        = pc_q + 16'd2;
      inflight_d  = 1'b1;
      req_epoch_d = epoch_q;
    end else if (w_accept) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      hold_q      <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      hold_q      <= hold_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  instr_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect_valid),
    .wr_en_i   (w_accept),
    .wr_grp_i  (imem_rdata),
    .consume_i (w_consume),
    .rd0_o     (w_rd0),
    .rd1_o     (w_rd1),
    .count_o   (w_count)
  );

  assign instr1_o = (!redirect_valid && w_count >= CNT_W'(1)) ? w_rd0 : NOP;
  assign instr2_o = (!redirect_valid && !hold_q && w_count >= CNT_W'(2)) ? w_rd1 : NOP;
endmodule
`default_nettype wire
